// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive arbiter: channel sizing, FSM
// encoding and the per-channel slot record.
package uart_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int SLOT_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    PRESENT = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic       full;
    logic       err;
    logic [7:0] data;
  } slot_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first full slot at or above rr_ptr, wrapping at N-1.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N = uart_pkg::NUM_CH,
  parameter int W = uart_pkg::CH_W
) (
  input  logic [N-1:0] full,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] grant,
  output logic         any
);

  logic [W-1:0] idx;

  // Walk offsets from the far end down so the nearest full slot wins;
  // the W-bit add wraps because N is a power of two.
  always_comb begin
    grant = rr_ptr;
    idx   = rr_ptr;
    for (int k = N - 1; k >= 0; k--) begin
      idx = rr_ptr + W'(k);
      if (full[idx]) grant = idx;
    end
  end

  assign any = |full;

endmodule

// File: rtl/uart_rx_arbiter.sv
// Merges NUM_CH UART receivers into one byte stream with round-robin grants.
// Define UART_RX_ERR_DROP_EN to drop errored frames and count them in drop_cnt.
module uart_rx_arbiter #(
  parameter int NUM_CH = uart_pkg::NUM_CH,
  parameter int CH_W   = uart_pkg::CH_W
) (
  input  logic                  sample_clk,
  input  logic                  rstn,
  input  logic [8*NUM_CH-1:0]   rx_data,
  input  logic [NUM_CH-1:0]     rx_done,
  input  logic [NUM_CH-1:0]     rx_err,
  output logic [NUM_CH-1:0]     rx_not_ready,
  output logic [7:0]            out_data,
  output logic [CH_W-1:0]       out_chan,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [NUM_CH-1:0]     ovr_clr,
  output logic [NUM_CH-1:0]     overrun,
  output logic [7:0]            drop_cnt
);

  import uart_pkg::*;

`ifdef UART_RX_ERR_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  slot_t             slot_reg [NUM_CH];
  logic [NUM_CH-1:0] full_vec, rel, accept, ovr_set, drop;
  logic [NUM_CH-1:0] overrun_reg;
  arb_state_t        state_reg;
  logic [CH_W-1:0]   rr_ptr_reg, grant_reg, pick_grant;
  logic              pick_any;
  logic [7:0]        out_data_reg;
  logic [CH_W-1:0]   out_chan_reg;
  logic              out_err_reg, out_valid_reg;
  logic [7:0]        drop_cnt_reg, drop_cnt_next;
  logic [CH_W:0]     drop_sum;
  logic [8:0]        drop_total;

  // A slot frees only on the handshake edge; a frame landing on that same
  // edge refills it instead of counting as an overrun.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign full_vec[gi] = slot_reg[gi].full;
    assign rel[gi]      = (state_reg == PRESENT) && out_ready && (grant_reg == CH_W'(gi));
    assign accept[gi]   = rx_done[gi] && (!slot_reg[gi].full || rel[gi]);
    assign ovr_set[gi]  = rx_done[gi] && slot_reg[gi].full && !rel[gi];
    assign drop[gi]     = DROP_EN && accept[gi] && rx_err[gi];
  end

  uart_rr_pick #(.N(NUM_CH), .W(CH_W)) u_pick (
    .full   (full_vec),
    .rr_ptr (rr_ptr_reg),
    .grant  (pick_grant),
    .any    (pick_any)
  );

  always_ff @(posedge sample_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) slot_reg[i] <= '0;
      overrun_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i] && !drop[i])
          slot_reg[i] <= '{full: 1'b1, err: rx_err[i] && !DROP_EN, data: rx_data[8*i +: 8]};
        else if (rel[i])
          slot_reg[i].full <= 1'b0;
        // A new loss beats a clear arriving on the same edge.
        if (ovr_set[i])
          overrun_reg[i] <= 1'b1;
        else if (ovr_clr[i])
          overrun_reg[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < NUM_CH; i++) drop_sum = drop_sum + (CH_W + 1)'(drop[i]);
    drop_total    = {1'b0, drop_cnt_reg} + 9'(drop_sum);
    drop_cnt_next = drop_total[8] ? 8'hFF : drop_total[7:0];
  end

  always_ff @(posedge sample_clk or negedge rstn) begin
    if (!rstn) drop_cnt_reg <= '0;
    else       drop_cnt_reg <= drop_cnt_next;
  end

  always_ff @(posedge sample_clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_err_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            grant_reg <= pick_grant;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          out_data_reg  <= slot_reg[grant_reg].data;
          out_chan_reg  <= grant_reg;
          out_err_reg   <= slot_reg[grant_reg].err;
          out_valid_reg <= 1'b1;
          state_reg     <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            rr_ptr_reg    <= grant_reg + CH_W'(1);
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rx_not_ready = full_vec;
  assign out_data     = out_data_reg;
  assign out_chan     = out_chan_reg;
  assign out_err      = out_err_reg;
  assign out_valid    = out_valid_reg;
  assign overrun      = overrun_reg;
  assign drop_cnt     = drop_cnt_reg;

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Directed self-checking bench for uart_rx_arbiter; honours UART_RX_ERR_DROP_EN.
module tb_uart_rx_arbiter;

  logic        sample_clk = 1'b0;
  logic        rstn;
  logic [31:0] rx_data;
  logic [3:0]  rx_done, rx_err, rx_not_ready, ovr_clr, overrun;
  logic [7:0]  out_data, drop_cnt;
  logic [1:0]  out_chan;
  logic        out_err, out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  always #5 sample_clk = ~sample_clk;

  uart_rx_arbiter dut (
    .sample_clk   (sample_clk),
    .rstn         (rstn),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_err       (rx_err),
    .rx_not_ready (rx_not_ready),
    .out_data     (out_data),
    .out_chan     (out_chan),
    .out_err      (out_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ovr_clr      (ovr_clr),
    .overrun      (overrun),
    .drop_cnt     (drop_cnt)
  );

  task automatic step();
    @(negedge sample_clk);
  endtask

  task automatic send(input int ch, input logic [7:0] d, input logic e);
    rx_data[8*ch +: 8] = d;
    rx_done[ch] = 1'b1;
    rx_err[ch]  = e;
    step();
    rx_done = '0;
    rx_err  = '0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; rx_data = '0; rx_done = '0; rx_err = '0; ovr_clr = '0; out_ready = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", out_chan); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", out_err); end
    checks++; if (rx_not_ready !== 4'b0000) begin errors++; $display("FAIL reset_nrdy: got %b expected 0000", rx_not_ready); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL reset_ovr: got %b expected 0000", overrun); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    rstn = 1'b1;
    step();
    $display("reset: released");
  endtask

  task automatic test_simultaneous();
    int n = 0;
    bit ok;
    out_ready = 1'b1;
    rx_data = 32'h13121110;
    rx_done = 4'hF;
    step();
    rx_done = '0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      if (out_valid) begin
        checks++; if (out_chan !== 2'(n)) begin errors++; $display("FAIL simul_order: got chan %0d expected %0d", out_chan, n); end
        checks++; if (out_data !== 8'(8'h10 + n)) begin errors++; $display("FAIL simul_data: got %h expected %h", out_data, 8'(8'h10 + n)); end
        $display("simultaneous: delivered chan %0d data %h", out_chan, out_data);
        n++;
      end
      step();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL simul_count: got %0d expected 4", n); end
    // rr_ptr should be back at 0, so channel 0 beats channel 3
    rx_data = 32'hBB0000AA;
    rx_done = 4'b1001;
    step();
    rx_done = '0;
    wait_valid(10, ok);
    checks++; if (!ok || out_chan !== 2'd0) begin errors++; $display("FAIL rr_wrap_first: got chan %0d valid %b expected chan 0", out_chan, ok); end
    step();
    wait_valid(10, ok);
    checks++; if (!ok || out_chan !== 2'd3) begin errors++; $display("FAIL rr_wrap_second: got chan %0d valid %b expected chan 3", out_chan, ok); end
    step();
    $display("simultaneous: rr wrap order checked");
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    rx_data[23:16] = 8'hA5;
    rx_done = 4'b0100;
    step();
    rx_done = '0;
    checks++; if (rx_not_ready !== 4'b0100) begin errors++; $display("FAIL single_capture: got %b expected 0100", rx_not_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_lat0: got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_lat1: got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_lat2: got %b expected 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", out_data); end
    checks++; if (out_chan !== 2'd2) begin errors++; $display("FAIL single_chan: got %0d expected 2", out_chan); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop_valid: got %b expected 0", out_valid); end
    checks++; if (rx_not_ready !== 4'b0000) begin errors++; $display("FAIL single_release: got %b expected 0000", rx_not_ready); end
    $display("single: chan 2 data a5 delivered");
  endtask

  task automatic test_backpressure();
    bit ok;
    out_ready = 1'b0;
    send(1, 8'h3C, 1'b0);
    wait_valid(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no out_valid expected out_valid"); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_data !== 8'h3C || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got data %h valid %b expected 3c 1", out_data, out_valid); end
      checks++; if (rx_not_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_nrdy: got %b expected 1", rx_not_ready[1]); end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || rx_not_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_release: got valid %b nrdy %b expected 0 0", out_valid, rx_not_ready[1]); end
    $display("backpressure: held 10 cycles then released");
  endtask

  task automatic test_overrun();
    bit ok;
    out_ready = 1'b0;
    send(1, 8'h11, 1'b0);
    send(1, 8'h22, 1'b0);
    checks++; if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_set: got %b expected 0010", overrun); end
    rx_data[15:8] = 8'h44; rx_done[1] = 1'b1; ovr_clr[1] = 1'b1;
    step();
    rx_done = '0; ovr_clr = '0;
    checks++; if (overrun[1] !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b expected 1", overrun[1]); end
    ovr_clr[1] = 1'b1;
    step();
    ovr_clr = '0;
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_clr: got %b expected 0000", overrun); end
    wait_valid(10, ok);
    checks++; if (!ok || out_data !== 8'h11) begin errors++; $display("FAIL ovr_first_byte: got %h valid %b expected 11", out_data, ok); end
    // release and a new frame on the same edge
    rx_data[15:8] = 8'h33; rx_done[1] = 1'b1; out_ready = 1'b1;
    step();
    rx_done = '0; out_ready = 1'b0;
    checks++; if (rx_not_ready[1] !== 1'b1 || overrun[1] !== 1'b0) begin errors++; $display("FAIL ovr_refill: got nrdy %b ovr %b expected 1 0", rx_not_ready[1], overrun[1]); end
    wait_valid(10, ok);
    checks++; if (!ok || out_data !== 8'h33) begin errors++; $display("FAIL ovr_refill_data: got %h valid %b expected 33", out_data, ok); end
    out_ready = 1'b1;
    step();
    $display("overrun: set, set-wins, clear, refill checked");
  endtask

  task automatic test_error();
    bit ok;
    out_ready = 1'b1;
    send(3, 8'h77, 1'b1);
`ifdef UART_RX_ERR_DROP_EN
    ok = 1'b0;
    checks++; if (rx_not_ready !== 4'b0000) begin errors++; $display("FAIL err_drop_slot: got %b expected 0000", rx_not_ready); end
    for (int i = 0; i < 6; i++) begin
      if (out_valid) ok = 1'b1;
      step();
    end
    checks++; if (ok) begin errors++; $display("FAIL err_drop_valid: got out_valid expected none"); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL err_drop_cnt: got %0d expected 1", drop_cnt); end
    $display("error: frame dropped, drop_cnt %0d", drop_cnt);
`else
    wait_valid(10, ok);
    checks++; if (!ok || out_chan !== 2'd3 || out_err !== 1'b1) begin errors++; $display("FAIL err_fwd: got chan %0d err %b valid %b expected 3 1 1", out_chan, out_err, ok); end
    checks++; if (out_data !== 8'h77) begin errors++; $display("FAIL err_fwd_data: got %h expected 77", out_data); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL err_drop_cnt: got %0d expected 0", drop_cnt); end
    step();
    $display("error: frame forwarded with out_err");
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b0;
    rx_data = 32'h00C3005A;
    rx_done = 4'b0101;
    step();
    rx_done = '0;
    wait_valid(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout: got no out_valid expected out_valid"); end
    #1 rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin errors++; $display("FAIL rmid_outs: got valid %b data %h chan %0d expected 0 00 0", out_valid, out_data, out_chan); end
    checks++; if (rx_not_ready !== 4'b0000 || overrun !== 4'b0000) begin errors++; $display("FAIL rmid_slots: got nrdy %b ovr %b expected 0000 0000", rx_not_ready, overrun); end
    step();
    rstn = 1'b1;
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) ok = 1'b1;
    end
    checks++; if (ok) begin errors++; $display("FAIL rmid_ghost: got out_valid after reset expected none"); end
    $display("reset_mid: pending bytes discarded");
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_backpressure();
    test_overrun();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
